// File: rtl/led_chase_sequencer.sv
// One-hot running-light sequencer with a clock prescaler, an up/down/bounce FSM and a command port.
// Optional pause input is enabled by defining LED_SEQ_PAUSE_EN.
module led_chase_sequencer #(
  parameter int LEDS     = 8,
  parameter int TICK_DIV = 3,
  parameter int DIV_W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  input  logic [1:0]      cmd_op,
  output logic            cmd_ready,
  output logic [LEDS-1:0] led,
  output logic            busy,
  output logic            wrap
`ifdef LED_SEQ_PAUSE_EN
  ,
  input  logic            pause
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  localparam logic [1:0] OP_STOP     = 2'b00;
  localparam logic [1:0] OP_RUN_UP   = 2'b01;
  localparam logic [1:0] OP_RUN_DOWN = 2'b10;
  localparam logic [1:0] OP_BOUNCE   = 2'b11;

  localparam logic [LEDS-1:0]  LED_LSB  = {{(LEDS-1){1'b0}}, 1'b1};
  localparam logic [LEDS-1:0]  LED_MSB  = LED_LSB << (LEDS-1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  state_t            state_q, state_d;
  logic [LEDS-1:0]   led_q, led_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              bounce_q, bounce_d;
  logic              wrap_q, wrap_d;
  logic              pause_w;
  logic              running;
  logic              step;
  logic              accept;

`ifdef LED_SEQ_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  assign running   = (state_q != IDLE);
  assign step      = running && !pause_w && (div_q == DIV_LAST);
  assign cmd_ready = !running || step;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d  = state_q;
    led_d    = led_q;
    div_d    = div_q;
    bounce_d = bounce_q;
    wrap_d   = 1'b0;

    if (running && !pause_w) begin
      div_d = step ? '0 : div_q + 1'b1;
    end

    // An accepted command takes priority over the step it coincides with.
    if (accept) begin
      div_d    = '0;
      bounce_d = 1'b0;
      case (cmd_op)
        OP_STOP: begin
          state_d = IDLE;
          led_d   = '0;
        end
        OP_RUN_UP: begin
          state_d = UP;
          led_d   = LED_LSB;
        end
        OP_RUN_DOWN: begin
          state_d = DOWN;
          led_d   = LED_MSB;
        end
        OP_BOUNCE: begin
          state_d  = UP;
          led_d    = LED_LSB;
          bounce_d = 1'b1;
        end
        default: ;
      endcase
    end else if (step) begin
      case (state_q)
        UP: begin
          if (!led_q[LEDS-1]) begin
            led_d = led_q << 1;
          end else begin
            wrap_d = 1'b1;
            if (bounce_q) begin
              led_d   = led_q >> 1;
              state_d = DOWN;
            end else begin
              led_d = LED_LSB;
            end
          end
        end
        DOWN: begin
          if (!led_q[0]) begin
            led_d = led_q >> 1;
          end else begin
            wrap_d = 1'b1;
            if (bounce_q) begin
              led_d   = led_q << 1;
              state_d = UP;
            end else begin
              led_d = LED_MSB;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      led_q    <= '0;
      div_q    <= '0;
      bounce_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      led_q    <= led_d;
      div_q    <= div_d;
      bounce_q <= bounce_d;
      wrap_q   <= wrap_d;
    end
  end

  assign led  = led_q;
  assign wrap = wrap_q;
  assign busy = running;

endmodule

// File: tb/tb_led_chase_sequencer.sv
// Directed bench for led_chase_sequencer (LEDS=8, TICK_DIV=3); pause scenario only with LED_SEQ_PAUSE_EN.
module tb_led_chase_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic       cmd_ready;
  logic [7:0] led;
  logic       busy;
  logic       wrap;
`ifdef LED_SEQ_PAUSE_EN
  logic       pause = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  led_chase_sequencer #(.LEDS(8), .TICK_DIV(3), .DIV_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_ready (cmd_ready),
    .led       (led),
    .busy      (busy),
    .wrap      (wrap)
`ifdef LED_SEQ_PAUSE_EN
    ,
    .pause     (pause)
`endif
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Waits (bounded) for cmd_ready, then presents op for exactly one accepting edge.
  // Returns at the negedge after acceptance (cycle 1 of the new pattern).
  task automatic send(input logic [1:0] op);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      next_cycle();
      n++;
    end
    total++;
    if (n >= 20) begin
      bad++;
      $display("FAIL send_timeout op=%0d: cmd_ready=%b required 1 within 20 cycles", op, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    next_cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) next_cycle();
    total++;
    if ({led, busy, wrap, cmd_ready} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_hold: led=%h busy=%b wrap=%b ready=%b required 00 0 0 1", led, busy, wrap, cmd_ready);
    end
    rst_n = 1'b1;
    next_cycle();
    total++;
    if ({led, busy, wrap, cmd_ready} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_release: led=%h busy=%b wrap=%b ready=%b required 00 0 0 1", led, busy, wrap, cmd_ready);
    end
  endtask

  task automatic test_idle_no_cmd();
    cmd_op = 2'b01;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      total++;
      if ({led, busy, cmd_ready} !== {8'h00, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL idle_no_cmd[%0d]: led=%h busy=%b ready=%b required 00 0 1", i, led, busy, cmd_ready);
      end
    end
  endtask

  // RUN_UP for 27 cycles: every position held 3 clocks, ready on the 3rd, wrap after 80->01.
  task automatic test_run_up();
    logic [7:0] exp_led;
    logic       exp_rdy;
    logic       exp_wrap;
    int         pos;
    send(2'b01);
    for (int k = 1; k <= 27; k++) begin
      pos      = (k - 1) / 3;
      exp_led  = 8'h01 << (pos % 8);
      exp_rdy  = ((k - 1) % 3 == 2);
      exp_wrap = (k == 25);
      total++;
      if ({led, cmd_ready, wrap, busy} !== {exp_led, exp_rdy, exp_wrap, 1'b1}) begin
        bad++;
        $display("FAIL run_up k=%0d: led=%h ready=%b wrap=%b busy=%b required %h %b %b 1",
                 k, led, cmd_ready, wrap, busy, exp_led, exp_rdy, exp_wrap);
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    send(2'b01);
    repeat (6) next_cycle();
    total++;
    if (led !== 8'h04) begin
      bad++;
      $display("FAIL restart_pre: led=%h required 04", led);
    end
    send(2'b01);
    total++;
    if ({led, cmd_ready} !== {8'h01, 1'b0}) begin
      bad++;
      $display("FAIL restart_same_op: led=%h ready=%b required 01 0", led, cmd_ready);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] seq [17];
    logic       exp_wrap;
    int         pos;
    seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
            8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    send(2'b11);
    for (int k = 1; k <= 51; k++) begin
      pos      = (k - 1) / 3;
      exp_wrap = ((k - 1) % 3 == 0) && (pos == 8 || pos == 15);
      total++;
      if ({led, wrap, busy} !== {seq[pos], exp_wrap, 1'b1}) begin
        bad++;
        $display("FAIL bounce k=%0d: led=%h wrap=%b busy=%b required %h %b 1",
                 k, led, wrap, busy, seq[pos], exp_wrap);
      end
      next_cycle();
    end
  endtask

  task automatic test_stop_hold();
    send(2'b10);
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      total++;
      if ({led, busy, cmd_ready} !== {8'h80, 1'b1, (k == 3)}) begin
        bad++;
        $display("FAIL stop_hold k=%0d: led=%h busy=%b ready=%b required 80 1 %b",
                 k, led, busy, cmd_ready, (k == 3));
      end
      next_cycle();
    end
    cmd_valid = 1'b0;
    total++;
    if ({led, busy, cmd_ready} !== {8'h00, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL stop_applied: led=%h busy=%b ready=%b required 00 0 1", led, busy, cmd_ready);
    end
  endtask

  task automatic test_async_reset();
    send(2'b10);
    repeat (3) next_cycle();
    total++;
    if ({led, busy} !== {8'h40, 1'b1}) begin
      bad++;
      $display("FAIL areset_pre: led=%h busy=%b required 40 1", led, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({led, busy, wrap} !== {8'h00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL areset_immediate: led=%h busy=%b wrap=%b required 00 0 0", led, busy, wrap);
    end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    total++;
    if ({led, busy, cmd_ready} !== {8'h00, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL areset_after: led=%h busy=%b ready=%b required 00 0 1", led, busy, cmd_ready);
    end
  endtask

`ifdef LED_SEQ_PAUSE_EN
  task automatic test_pause();
    send(2'b01);
    repeat (10) next_cycle();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      total++;
      if ({led, cmd_ready, wrap} !== {8'h08, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL pause_hold[%0d]: led=%h ready=%b wrap=%b required 08 0 0", i, led, cmd_ready, wrap);
      end
    end
    pause = 1'b0;
    next_cycle();
    total++;
    if ({led, cmd_ready} !== {8'h08, 1'b1}) begin
      bad++;
      $display("FAIL pause_resume1: led=%h ready=%b required 08 1", led, cmd_ready);
    end
    next_cycle();
    total++;
    if ({led, cmd_ready} !== {8'h10, 1'b0}) begin
      bad++;
      $display("FAIL pause_resume2: led=%h ready=%b required 10 0", led, cmd_ready);
    end
    send(2'b00);
    pause = 1'b1;
    send(2'b00);
    total++;
    if ({led, busy, cmd_ready} !== {8'h00, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL pause_idle_stop: led=%h busy=%b ready=%b required 00 0 1", led, busy, cmd_ready);
    end
    pause = 1'b0;
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_idle_no_cmd();
    test_run_up();
    test_back_to_back();
    test_bounce();
    test_stop_hold();
    test_async_reset();
`ifdef LED_SEQ_PAUSE_EN
    test_pause();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
